alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Parameters
REQ-001 TIMEOUT, default 8, max cycles in WAIT for alu_ready before an error response.

Interface
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-005 req0_ready / req1_ready  output  1  request N accepted this cycle (valid && ready).
REQ-006 req0_a, req0_b / req1_a, req1_b  input  32  operands of requester N.
REQ-007 req0_op / req1_op  input  2  opcode: 00 add, 01 sub, 10 mul, 11 div.
REQ-008 rsp0_valid / rsp1_valid  output  1  response for requester N available.
REQ-009 rsp0_ready / rsp1_ready  input  1  requester N consumes its response.
REQ-010 rsp0_result / rsp1_result  output  32  ALU result for requester N.
REQ-011 rsp0_err / rsp1_err  output  1  1 = divide-by-zero or timeout; result is 0.
REQ-012 alu_a, alu_b  output  32  operands driven to shared ALU.
REQ-013 alu_opcode  output  2  opcode driven to shared ALU.
REQ-014 alu_result  input  32  ALU result.
REQ-015 alu_ready  input  1  ALU result valid.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one operation in flight.
REQ-018 IDLE: if any reqN_valid, grant one, assert that reqN_ready combinationally in the same cycle, latch a/b/op and grant id, go ISSUE; else stay.
REQ-019 Arbitration round-robin: both valid -> grant the requester not granted last; one valid -> grant it regardless of history.
REQ-020 reqN_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-021 alu_a/alu_b/alu_opcode SHALL be driven from latched registers only; they hold stable from ISSUE through WAIT.
REQ-022 ISSUE: if latched op = 11 and latched b = 0, set err=1, result=0, go RESP without waiting; else clear timeout counter, go WAIT.
REQ-023 WAIT: alu_ready=1 -> capture alu_result, err=0, go RESP; else increment counter; counter reaching TIMEOUT-1 with alu_ready=0 -> err=1, result=0, go RESP.
REQ-024 RESP: assert rspN_valid for granted requester only, with result/err stable; on rspN_ready=1 go IDLE and record grant id as last granted.
REQ-025 rspN_valid SHALL stay high until rspN_ready; no new request is accepted while in RESP.
REQ-026 Minimum latency: accept at cycle T, ISSUE T+1, WAIT T+2 (alu_ready=1), rspN_valid at T+3; divide-by-zero rspN_valid at T+2.
REQ-027 New request may be accepted the cycle after the RESP handshake (IDLE), not in the same cycle.
REQ-028 Arithmetic is performed solely by the external ALU; the block does not modify alu_result.
REQ-029 Non-granted rspN_result/rspN_err SHALL hold their previous values; only rspN_valid qualifies them.

Reset
REQ-030 rst=1 SHALL immediately force state IDLE, counter 0, last granted = requester 1 (requester 0 wins first tie).
REQ-031 During reset all outputs SHALL be 0: reqN_ready, rspN_valid, rspN_result, rspN_err, alu_a, alu_b, alu_opcode, busy.
REQ-032 Reset mid-operation SHALL abort the in-flight operation with no response issued; operation is not replayed.

Verification
REQ-033 req0 only, a=10 b=20 op=00, alu_ready=1 -> rsp0_valid at T+3, rsp0_result=30, rsp0_err=0, rsp1_valid never high.
REQ-034 req0 and req1 both valid every cycle after reset (req0 a=50 b=15 op=01, req1 a=7 b=8 op=10) -> grants alternate 0,1,0,1; rsp0_result=35, rsp1_result=56.
REQ-035 req1 a=100 b=0 op=11 -> no WAIT state, rsp1_valid at T+2, rsp1_err=1, rsp1_result=0.
REQ-036 req0 a=100 b=5 op=11 with alu_ready held 0 -> after TIMEOUT WAIT cycles rsp0_valid=1, rsp0_err=1, rsp0_result=0.
REQ-037 rsp0_ready held 0 for 5 cycles with req1_valid=1 -> rsp0_valid and result stable, req1_ready=0 throughout; req1 accepted the cycle after rsp0_ready=1 handshake.
REQ-038 rst asserted in WAIT -> all outputs 0 same cycle, no response after release, next tie granted to requester 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one external ALU between two requesters,
// with divide-by-zero short-circuit and ALU timeout error responses.
module alu_arbiter #(
    parameter int TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [31:0] rsp0_result,
    output logic        rsp0_err,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [31:0] rsp1_result,
    output logic        rsp1_err,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [1:0]  alu_opcode,
    input  logic [31:0] alu_result,
    input  logic        alu_ready,
    output logic        busy
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d, last_q, last_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [1:0][31:0] res_q, res_d;
    logic [1:0]       err_q, err_d;
    logic             pick;

    // Tie goes to the requester not served last; a lone requester always wins.
    assign pick = (req0_valid && req1_valid) ? !last_q : !req0_valid;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: if (req0_valid || req1_valid) begin
                gnt_d   = pick;
                a_d     = pick ? req1_a : req0_a;
                b_d     = pick ? req1_b : req0_b;
                op_d    = pick ? req1_op : req0_op;
                state_d = ISSUE;
            end
            ISSUE: if (op_q == 2'b11 && b_q == '0) begin
                res_d[gnt_q] = '0;
                err_d[gnt_q] = 1'b1;
                state_d      = RESP;
            end else begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (alu_ready || cnt_q == CW'(TIMEOUT - 1)) begin
                res_d[gnt_q] = alu_ready ? alu_result : '0;
                err_d[gnt_q] = !alu_ready;
                state_d      = RESP;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            RESP: if (gnt_q ? rsp1_ready : rsp0_ready) begin
                last_d  = gnt_q;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 1'b0;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    // Ready is combinational from the inputs, so it must be masked while reset is held.
    assign req0_ready  = !rst && state_q == IDLE && req0_valid && !pick;
    assign req1_ready  = !rst && state_q == IDLE && req1_valid && pick;
    assign rsp0_valid  = state_q == RESP && !gnt_q;
    assign rsp1_valid  = state_q == RESP && gnt_q;
    assign rsp0_result = res_q[0];
    assign rsp1_result = res_q[1];
    assign rsp0_err    = err_q[0];
    assign rsp1_err    = err_q[1];
    assign alu_a       = a_q;
    assign alu_b       = b_q;
    assign alu_opcode  = op_q;
    assign busy        = state_q != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: transaction-level model of the arbiter, directed scenarios plus
// randomized traffic with a scripted ALU responder.
module tb_alu_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_op, req1_op;
    logic        rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] rsp0_result, rsp1_result;
    logic        rsp0_err, rsp1_err;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_opcode;
    logic        alu_ready, busy;

    int checks = 0;
    int errors = 0;

    logic        last_m;
    logic [31:0] res_m [2];
    logic        err_m [2];

    alu_arbiter #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_err(rsp0_err),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_err(rsp1_err),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
        .alu_result(alu_result), .alu_ready(alu_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a * b;
            default: return b == 0 ? 32'd0 : a / b;
        endcase
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            cyc();
            #1;
            chk("idle_busy", busy, 0);
            chk("idle_req0_ready", req0_ready, 0);
            chk("idle_req1_ready", req1_ready, 0);
            chk("idle_rsp0_valid", rsp0_valid, 0);
            chk("idle_rsp1_valid", rsp1_valid, 0);
        end
    endtask

    // One accepted operation: k = WAIT cycle on which the ALU answers (>= TO means never),
    // d = cycles the response is held before the requester consumes it.
    task automatic txn(input logic v0, input logic v1,
                       input logic [31:0] a0, input logic [31:0] b0, input logic [1:0] op0,
                       input logic [31:0] a1, input logic [31:0] b1, input logic [1:0] op1,
                       input int k, input int d);
        logic        g, div0, ee;
        logic [31:0] ga, gb, er;
        logic [1:0]  gop;
        int          r;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
        alu_ready  = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        g    = (v0 && v1) ? !last_m : !v0;
        ga   = g ? a1 : a0;
        gb   = g ? b1 : b0;
        gop  = g ? op1 : op0;
        div0 = gop == 2'b11 && gb == 0;
        r    = div0 ? 2 : (k < TO ? 3 + k : 2 + TO);
        ee   = div0 || k >= TO;
        er   = ee ? 32'd0 : ref_alu(ga, gb, gop);
        #1;
        chk("accept_req0_ready", req0_ready, v0 && !g);
        chk("accept_req1_ready", req1_ready, g);
        chk("accept_busy", busy, 0);
        for (int c = 1; c < r; c++) begin
            cyc();
            alu_ready  = !div0 && c == 2 + k;
            alu_result = alu_ready ? ref_alu(ga, gb, gop) : $urandom;
            #1;
            chk("op_busy", busy, 1);
            chk("op_req0_ready", req0_ready, 0);
            chk("op_req1_ready", req1_ready, 0);
            chk("op_rsp0_valid", rsp0_valid, 0);
            chk("op_rsp1_valid", rsp1_valid, 0);
            chk("op_alu_a", alu_a, ga);
            chk("op_alu_b", alu_b, gb);
            chk("op_alu_opcode", alu_opcode, gop);
            chk("op_rsp0_result_hold", rsp0_result, res_m[0]);
            chk("op_rsp1_result_hold", rsp1_result, res_m[1]);
        end
        res_m[g] = er;
        err_m[g] = ee;
        for (int j = 0; j <= d; j++) begin
            cyc();
            alu_ready  = 1'b0;
            rsp0_ready = !g && j == d;
            rsp1_ready = g && j == d;
            #1;
            chk("rsp_rsp0_valid", rsp0_valid, !g);
            chk("rsp_rsp1_valid", rsp1_valid, g);
            chk("rsp_rsp0_result", rsp0_result, res_m[0]);
            chk("rsp_rsp1_result", rsp1_result, res_m[1]);
            chk("rsp_rsp0_err", rsp0_err, err_m[0]);
            chk("rsp_rsp1_err", rsp1_err, err_m[1]);
            chk("rsp_req0_ready", req0_ready, 0);
            chk("rsp_req1_ready", req1_ready, 0);
            chk("rsp_busy", busy, 1);
        end
        cyc();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        last_m     = g;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req0_ready"}, req0_ready, 0);
        chk({tag, "_req1_ready"}, req1_ready, 0);
        chk({tag, "_rsp0_valid"}, rsp0_valid, 0);
        chk({tag, "_rsp1_valid"}, rsp1_valid, 0);
        chk({tag, "_rsp0_result"}, rsp0_result, 0);
        chk({tag, "_rsp1_result"}, rsp1_result, 0);
        chk({tag, "_rsp0_err"}, rsp0_err, 0);
        chk({tag, "_rsp1_err"}, rsp1_err, 0);
        chk({tag, "_alu_a"}, alu_a, 0);
        chk({tag, "_alu_b"}, alu_b, 0);
        chk({tag, "_alu_opcode"}, alu_opcode, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic        v0, v1;
        logic [31:0] ra0, rb0, ra1, rb1;
        logic [1:0]  rop0, rop1;
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
        req1_a = 0; req1_b = 0; req1_op = 0;
        rsp0_ready = 0; rsp1_ready = 0; alu_ready = 0; alu_result = 0;
        last_m = 1'b1;
        res_m[0] = 0; res_m[1] = 0; err_m[0] = 0; err_m[1] = 0;
        cyc();
        cyc();
        chk_all_zero("reset");
        rst = 1'b0;
        idle(2);

        txn(1, 0, 10, 20, 2'b00, 0, 0, 2'b00, 0, 0);
        idle(1);
        last_m = 1'b1;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        res_m[0] = 0;
        err_m[0] = 0;
        for (int i = 0; i < 4; i++) txn(1, 1, 50, 15, 2'b01, 7, 8, 2'b10, 0, 0);
        chk("alt_rsp0_result", rsp0_result, 35);
        chk("alt_rsp1_result", rsp1_result, 56);
        txn(1, 1, 3, 4, 2'b00, 9, 9, 2'b01, 1, 5);
        txn(0, 1, 0, 0, 2'b00, 6, 2, 2'b11, 0, 0);
        txn(0, 1, 0, 0, 2'b00, 100, 0, 2'b11, 0, 0);
        txn(1, 0, 100, 5, 2'b11, 0, 0, 2'b00, TO + 1, 1);
        txn(1, 0, 100, 5, 2'b11, 0, 0, 2'b00, TO - 1, 0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            v0   = 1'($urandom_range(0, 1));
            v1   = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            ra0  = $urandom; ra1 = $urandom;
            rb0  = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            rb1  = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom;
            rop0 = 2'($urandom_range(0, 3));
            rop1 = 2'($urandom_range(0, 3));
            txn(v0, v1, ra0, rb0, rop0, ra1, rb1, rop1, $urandom_range(0, TO + 1), $urandom_range(0, 3));
        end

        // Abort an operation in WAIT with an asynchronous reset while both requesters keep asking.
        req0_valid = 1; req0_a = 1; req0_b = 2; req0_op = 2'b00;
        req1_valid = 1; req1_a = 3; req1_b = 4; req1_op = 2'b00;
        alu_ready = 0;
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midrst");
        cyc();
        #1;
        chk_all_zero("midrst_hold");
        rst = 1'b0;
        last_m = 1'b1;
        res_m[0] = 0; res_m[1] = 0; err_m[0] = 0; err_m[1] = 0;
        idle(4);
        txn(1, 1, 40, 2, 2'b10, 5, 5, 2'b00, 0, 0);
        chk("post_rst_rsp0_result", rsp0_result, 80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
